perf_monitor: RTL and testbench



---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_sat_counter.sv | 34 +++
 rtl/perf_monitor.sv | 138 +++++++++++++
 tb/tb_perf_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] REG_STATUS    = 3'd0;
    localparam logic [2:0] REG_CYCLE     = 3'd1;
    localparam logic [2:0] REG_INSTRET   = 3'd2;
    localparam logic [2:0] REG_BUBBLE    = 3'd3;
    localparam logic [2:0] REG_ZERO_PC   = 3'd4;
    localparam logic [2:0] REG_LEDR_CAP  = 3'd5;
    localparam logic [2:0] REG_LEDR_BASE = 3'd6;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/perf_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear wins over increment.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// Measures cycles, retired instructions, bubbles and zero-PC cycles from program
// start (first non-zero PC) until the first LEDR change; results exposed on a read port.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int LEDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_pc_debug,
    input  logic              i_insn_vld,
    input  logic [LEDR_W-1:0] i_io_ledr,
    input  logic              i_clr,
    input  logic              i_rd_en,
    input  logic [2:0]        i_rd_addr,
    output logic [31:0]       o_rd_data,
    output logic              o_rd_vld,
    output logic              o_running,
    output logic              o_done
);

    state_e            state_q;
    logic              running_q;
    logic              done_q;
    logic [LEDR_W-1:0] ledr_base_q;
    logic [LEDR_W-1:0] ledr_cap_q;
    logic [31:0]       rd_data_q;
    logic              rd_vld_q;
    logic [31:0]       rd_data_d;

    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  zero_pc_cnt;

    logic pc_zero;
    logic count_en;

    // The IDLE->RUN edge is itself the first counted cycle.
    assign pc_zero  = (i_pc_debug == 32'd0);
    assign count_en = !i_clr && ((state_q == ST_RUN) || ((state_q == ST_IDLE) && !pc_zero));

    perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_inc(count_en), .o_cnt(cycle_cnt)
    );

    perf_sat_counter #(.CNT_W(CNT_W)) u_instret (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_inc(count_en && i_insn_vld), .o_cnt(instret_cnt)
    );

    perf_sat_counter #(.CNT_W(CNT_W)) u_bubble (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_inc(count_en && !i_insn_vld), .o_cnt(bubble_cnt)
    );

    perf_sat_counter #(.CNT_W(CNT_W)) u_zero_pc (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_inc(count_en && pc_zero), .o_cnt(zero_pc_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            ledr_base_q <= '0;
            ledr_cap_q  <= '0;
        end else if (i_clr) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            ledr_base_q <= '0;
            ledr_cap_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pc_zero) begin
                        state_q     <= ST_RUN;
                        running_q   <= 1'b1;
                        ledr_base_q <= i_io_ledr;
                    end
                end
                ST_RUN: begin
                    if (i_io_ledr != ledr_base_q) begin
                        state_q    <= ST_DONE;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        ledr_cap_q <= i_io_ledr;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data_d = 32'd0;
        case (i_rd_addr)
            REG_STATUS:    rd_data_d = {30'd0, done_q, running_q};
            REG_CYCLE:     rd_data_d = 32'(cycle_cnt);
            REG_INSTRET:   rd_data_d = 32'(instret_cnt);
            REG_BUBBLE:    rd_data_d = 32'(bubble_cnt);
            REG_ZERO_PC:   rd_data_d = 32'(zero_pc_cnt);
            REG_LEDR_CAP:  rd_data_d = 32'(ledr_cap_q);
            REG_LEDR_BASE: rd_data_d = 32'(ledr_base_q);
            default:       rd_data_d = 32'd0;
        endcase
    end

    // Read data holds its last value between strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_q <= 32'd0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= i_rd_en;
            if (i_rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_rd_vld  = rd_vld_q;
    assign o_running = running_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Scenario-driven bench for perf_monitor; read results flow through a scoreboard queue.
module tb_perf_monitor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] ledr;
    logic        clr;
    logic        clr4;
    logic        rdEn;
    logic        rdEn4;
    logic [2:0]  rdAddr;

    logic [31:0] rdData;
    logic        rdVld;
    logic        running;
    logic        done;
    logic [31:0] rdData4;
    logic        rdVld4;
    logic        running4;
    logic        done4;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } rdExp_t;

    rdExp_t sbQ[$];
    rdExp_t sbQ4[$];
    int total;
    int bad;
    logic [31:0] ex [8];

    perf_monitor dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_debug(pc), .i_insn_vld(vld),
        .i_io_ledr(ledr), .i_clr(clr), .i_rd_en(rdEn), .i_rd_addr(rdAddr),
        .o_rd_data(rdData), .o_rd_vld(rdVld), .o_running(running), .o_done(done)
    );

    perf_monitor #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_debug(pc), .i_insn_vld(vld),
        .i_io_ledr(ledr), .i_clr(clr4), .i_rd_en(rdEn4), .i_rd_addr(rdAddr),
        .o_rd_data(rdData4), .o_rd_vld(rdVld4), .o_running(running4), .o_done(done4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then retire any read responses against the scoreboard.
    task automatic tick();
        rdExp_t e;
        @(posedge clk);
        #1;
        if (rdVld === 1'b1) begin
            total++;
            if (sbQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL rd_vld_unexpected: got vld=1 want vld=0");
            end else begin
                e = sbQ.pop_front();
                if (rdData !== e.data) begin
                    bad++;
                    $display("[TB] FAIL rd_addr%0d: got %0d want %0d", e.addr, rdData, e.data);
                end
            end
        end else if (sbQ.size() != 0) begin
            total++;
            bad++;
            e = sbQ.pop_front();
            $display("[TB] FAIL rd_vld_missing addr%0d: got vld=%b want vld=1", e.addr, rdVld);
        end
        if (rdVld4 === 1'b1) begin
            total++;
            if (sbQ4.size() == 0) begin
                bad++;
                $display("[TB] FAIL rd4_vld_unexpected: got vld=1 want vld=0");
            end else begin
                e = sbQ4.pop_front();
                if (rdData4 !== e.data) begin
                    bad++;
                    $display("[TB] FAIL rd4_addr%0d: got %0d want %0d", e.addr, rdData4, e.data);
                end
            end
        end else if (sbQ4.size() != 0) begin
            total++;
            bad++;
            e = sbQ4.pop_front();
            $display("[TB] FAIL rd4_vld_missing addr%0d: got vld=%b want vld=1", e.addr, rdVld4);
        end
    endtask

    // Drive one cycle of core outputs and let the edge sample them.
    task automatic applyStimulus(input logic [31:0] pcV, input logic vldV, input logic [31:0] ledrV);
        pc   = pcV;
        vld  = vldV;
        ledr = ledrV;
        tick();
    endtask

    // Raise the read strobe for the next edge and record what that read must return.
    task automatic queueRead(input bit sel4, input logic [2:0] addr, input logic [31:0] expData);
        rdExp_t e;
        e.addr = addr;
        e.data = expData;
        rdAddr = addr;
        if (sel4) begin
            rdEn4 = 1'b1;
            sbQ4.push_back(e);
        end else begin
            rdEn = 1'b1;
            sbQ.push_back(e);
        end
    endtask

    // Back-to-back reads of the whole register map while inputs stay put.
    task automatic readAll(input bit sel4, input logic [31:0] expMap [8]);
        for (int i = 0; i < 8; i++) begin
            queueRead(sel4, 3'(i), expMap[i]);
            tick();
        end
        rdEn  = 1'b0;
        rdEn4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running: got %b want 0", running); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        total++; if (rdVld !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_vld: got %b want 0", rdVld); end
        total++; if (rdData !== 32'd0) begin bad++; $display("[TB] FAIL reset_rd_data: got %0d want 0", rdData); end
        tick();
        rst_n = 1'b1;
        tick();
        ex = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        readAll(1'b0, ex);
    endtask

    task automatic test_full_ipc();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) applyStimulus(32'd0, 1'b0, 32'd0);
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL idle_running: got %b want 0", running); end
        for (int c = 1; c <= 50; c++) begin
            applyStimulus(32'd4, 1'b1, (c == 50) ? 32'd120 : 32'd0);
            if (c == 1) begin
                total++; if (running !== 1'b1) begin bad++; $display("[TB] FAIL run_start: got %b want 1", running); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL ipc_done: got %b want 1", done); end
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL ipc_running: got %b want 0", running); end
        ex = '{32'd2, 32'd50, 32'd50, 32'd0, 32'd0, 32'd120, 32'd0, 32'd0};
        readAll(1'b0, ex);
    endtask

    task automatic test_insn_pattern();
        clr = 1'b1;
        applyStimulus(32'd0, 1'b0, 32'd120);
        clr = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL clr_done: got %b want 0", done); end
        for (int c = 1; c <= 30; c++) begin
            // Mid-run read: the edge of cycle 11 returns the count from before it.
            if (c == 11) queueRead(1'b0, 3'd1, 32'd10);
            applyStimulus(32'd4, (c % 3) != 0, (c == 30) ? 32'd55 : 32'd120);
            rdEn = 1'b0;
        end
        ex = '{32'd2, 32'd30, 32'd20, 32'd10, 32'd0, 32'd55, 32'd120, 32'd0};
        readAll(1'b0, ex);
    endtask

    task automatic test_flush_zero_pc();
        clr = 1'b1;
        applyStimulus(32'd0, 1'b0, 32'd55);
        clr = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c >= 5 && c <= 7) applyStimulus(32'd0, 1'b0, 32'd55);
            else applyStimulus(32'd8, 1'b1, (c == 20) ? 32'd99 : 32'd55);
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL flush_done: got %b want 1", done); end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'(i * 4), 1'(i), 32'(i * 3 + 7));
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_sticky: got %b want 1", done); end
        ex = '{32'd2, 32'd20, 32'd17, 32'd3, 32'd3, 32'd99, 32'd55, 32'd0};
        readAll(1'b0, ex);
    endtask

    task automatic test_saturation();
        clr4 = 1'b1;
        applyStimulus(32'd0, 1'b1, 32'd77);
        clr4 = 1'b0;
        repeat (20) applyStimulus(32'd4, 1'b1, 32'd77);
        total++; if (running4 !== 1'b1) begin bad++; $display("[TB] FAIL sat_running: got %b want 1", running4); end
        ex = '{32'd1, 32'd15, 32'd15, 32'd0, 32'd0, 32'd0, 32'd77, 32'd0};
        readAll(1'b1, ex);
    endtask

    task automatic test_clear_restart();
        clr = 1'b1;
        applyStimulus(32'd4, 1'b1, 32'd77);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL clr_in_done: got %b want 0", done); end
        applyStimulus(32'd4, 1'b1, 32'd77);
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL clr_held_running: got %b want 0", running); end
        clr = 1'b0;
        pc  = 32'd0;
        ex = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        readAll(1'b0, ex);
        repeat (3) applyStimulus(32'd4, 1'b1, 32'd77);
        queueRead(1'b0, 3'd1, 32'd3);
        applyStimulus(32'd4, 1'b1, 32'd77);
        rdEn = 1'b0;
    endtask

    task automatic test_reset_midrun();
        clr = 1'b1;
        applyStimulus(32'd0, 1'b0, 32'd77);
        clr = 1'b0;
        repeat (40) applyStimulus(32'd4, 1'b1, 32'd77);
        queueRead(1'b0, 3'd1, 32'd40);
        applyStimulus(32'd4, 1'b1, 32'd77);
        rdEn = 1'b0;
        applyStimulus(32'd4, 1'b1, 32'd77);
        rst_n = 1'b0;
        #1;
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_running: got %b want 0", running); end
        total++; if (rdData !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_rd_data: got %0d want 0", rdData); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_done: got %b want 0", done); end
        pc = 32'd0;
        tick();
        rst_n = 1'b1;
        tick();
        ex = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        readAll(1'b0, ex);
    endtask

    // Runs every scenario in order, then checks no read response went missing.
    initial begin
        total  = 0;
        bad    = 0;
        pc     = 32'd0;
        vld    = 1'b0;
        ledr   = 32'd0;
        clr    = 1'b0;
        clr4   = 1'b0;
        rdEn   = 1'b0;
        rdEn4  = 1'b0;
        rdAddr = 3'd0;
        test_reset();
        test_full_ipc();
        test_insn_pattern();
        test_flush_zero_pc();
        test_saturation();
        test_clear_restart();
        test_reset_midrun();
        total++;
        if ((sbQ.size() + sbQ4.size()) != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sbQ.size() + sbQ4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
